// File: rtl/hazard_scoreboard.sv
// Load-use hazard and forwarding unit: a shift-register scoreboard of in-flight
// destinations, one hazard_src lane per source operand.
module hazard_src #(
  parameter int REG_W    = 5,
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 2,
  parameter int SEL_W    = 2
) (
  input  logic [REG_W-1:0]             srcAddr,
  input  logic                         used,
  input  logic                         late,
  input  logic [STAGES:1]              entValid,
  input  logic [STAGES:1]              entWe,
  input  logic [STAGES:1]              entLoad,
  input  logic [STAGES:1][REG_W-1:0]   entRd,
  output logic                         srcStall,
  output logic [SEL_W-1:0]             fwdSel
);
  int   hitK;
  int   cons;
  logic hitLoad;

  always_comb begin
    hitK    = 0;
    hitLoad = 1'b0;
    // Scan oldest to youngest so the youngest producer overwrites older ones.
    for (int k = STAGES; k >= 1; k--) begin
      if (used && srcAddr != '0 && entValid[k] && entWe[k] && entRd[k] == srcAddr) begin
        hitK    = k;
        hitLoad = entLoad[k];
      end
    end
    cons     = hitK + (late ? 1 : 0);
    srcStall = (hitK != 0) && hitLoad && (cons < LOAD_LAT);
    fwdSel   = '0;
    if (hitK != 0 && !srcStall && cons <= STAGES) fwdSel = SEL_W'(cons);
  end
endmodule

module hazard_scoreboard #(
  parameter int REG_W    = 5,
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 2,
  parameter int NSRC     = 2,
  parameter int SEL_W    = $clog2(STAGES + 1),
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid,
  input  logic [REG_W-1:0]        issue_rd,
  input  logic                    issue_we,
  input  logic                    issue_is_load,
  input  logic [NSRC*REG_W-1:0]   src_addr,
  input  logic [NSRC-1:0]         src_used,
  input  logic [NSRC-1:0]         src_late,
  input  logic                    flush,
  output logic                    stall,
  output logic [NSRC*SEL_W-1:0]   fwd_sel,
  output logic [CNT_W-1:0]        stall_cycles
);
  logic [STAGES:1]            vldPipe;
  logic [STAGES:1]            wePipe;
  logic [STAGES:1]            ldPipe;
  logic [STAGES:1][REG_W-1:0] rdPipe;

  logic [NSRC-1:0]             srcStall;
  logic [NSRC-1:0][SEL_W-1:0]  fwdVec;

  for (genvar i = 0; i < NSRC; i++) begin : gSrc
    hazard_src #(.REG_W(REG_W), .STAGES(STAGES), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)) uSrc (
      .srcAddr  (src_addr[i*REG_W +: REG_W]),
      .used     (src_used[i]),
      .late     (src_late[i]),
      .entValid (vldPipe),
      .entWe    (wePipe),
      .entLoad  (ldPipe),
      .entRd    (rdPipe),
      .srcStall (srcStall[i]),
      .fwdSel   (fwdVec[i])
    );
  end

  // Flush overrides any hazard: the squashed issue must not hold the pipe.
  assign stall   = issue_valid & ~flush & (|srcStall);
  assign fwd_sel = fwdVec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vldPipe      <= '0;
      wePipe       <= '0;
      ldPipe       <= '0;
      rdPipe       <= '0;
      stall_cycles <= '0;
    end else begin
      vldPipe[1] <= issue_valid & ~stall & ~flush;
      wePipe[1]  <= issue_we;
      ldPipe[1]  <= issue_is_load;
      rdPipe[1]  <= issue_rd;
      // Flush also kills the youngest in-flight entry as it moves to stage 2.
      for (int k = 2; k <= STAGES; k++) begin
        vldPipe[k] <= (k == 2) ? (vldPipe[k-1] & ~flush) : vldPipe[k-1];
        wePipe[k]  <= wePipe[k-1];
        ldPipe[k]  <= ldPipe[k-1];
        rdPipe[k]  <= rdPipe[k-1];
      end
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: expectations queued at drive time,
// popped and compared on the falling edge.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        issue_valid, issue_we, issue_is_load, flush;
  logic [4:0]  issue_rd;
  logic [9:0]  src_addr;
  logic [1:0]  src_used, src_late;
  logic        stall, satStall;
  logic [3:0]  fwd_sel, satFwd;
  logic [15:0] stall_cycles;
  logic [3:0]  satCnt;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_we(issue_we), .issue_is_load(issue_is_load), .src_addr(src_addr),
    .src_used(src_used), .src_late(src_late), .flush(flush),
    .stall(stall), .fwd_sel(fwd_sel), .stall_cycles(stall_cycles)
  );

  // Narrow counter copy so saturation is reachable in a short run.
  hazard_scoreboard #(.CNT_W(4)) uSat (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_we(issue_we), .issue_is_load(issue_is_load), .src_addr(src_addr),
    .src_used(src_used), .src_late(src_late), .flush(flush),
    .stall(satStall), .fwd_sel(satFwd), .stall_cycles(satCnt)
  );

  typedef struct {
    string       tag;
    logic        stall;
    logic [1:0]  f0;
    logic [1:0]  f1;
    bit          chkFwd;
    logic [15:0] cnt;
    logic [3:0]  sat;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   modelCnt = 0;

  task automatic step(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                      input logic [4:0] s0, input logic [4:0] s1,
                      input logic [1:0] used, input logic [1:0] late, input logic fl,
                      input logic eSt, input logic [1:0] eF0, input logic [1:0] eF1,
                      input string tag);
    exp_t e;
    issue_valid = v; issue_rd = rd; issue_we = we; issue_is_load = ld;
    src_addr = {s1, s0}; src_used = used; src_late = late; flush = fl;
    e.tag = tag; e.stall = eSt; e.f0 = eF0; e.f1 = eF1; e.chkFwd = !eSt && !fl;
    e.cnt = 16'(modelCnt);
    e.sat = (modelCnt > 15) ? 4'hF : 4'(modelCnt);
    expQ.push_back(e);
    if (eSt) modelCnt++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, "idle");
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (stall !== e.stall) begin
        failures++; $display("FAIL %s stall: got %b want %b", e.tag, stall, e.stall);
      end
      checks++;
      if (stall_cycles !== e.cnt) begin
        failures++; $display("FAIL %s stall_cycles: got %0d want %0d", e.tag, stall_cycles, e.cnt);
      end
      checks++;
      if (satCnt !== e.sat || satStall !== e.stall) begin
        failures++; $display("FAIL %s sat_counter: got %0d/%b want %0d/%b", e.tag, satCnt, satStall, e.sat, e.stall);
      end
      if (e.chkFwd) begin
        checks++;
        if (fwd_sel[1:0] !== e.f0 || fwd_sel[3:2] !== e.f1) begin
          failures++;
          $display("FAIL %s fwd_sel: got src0=%0d src1=%0d want src0=%0d src1=%0d",
                   e.tag, fwd_sel[1:0], fwd_sel[3:2], e.f0, e.f1);
        end
      end
    end
  end

  task automatic test_reset();
    issue_valid = 0; issue_rd = 0; issue_we = 0; issue_is_load = 0;
    src_addr = 0; src_used = 0; src_late = 0; flush = 0;
    #2;
    checks++;
    if (stall !== 1'b0 || fwd_sel !== 4'h0 || stall_cycles !== 16'h0) begin
      failures++; $display("FAIL reset_state: got stall=%b fwd=%h cnt=%0d want 0/0/0", stall, fwd_sel, stall_cycles);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    idle(3);
    step(1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, "fwd_add");
    step(1, 10, 1, 0, 3, 0, 2'b01, 2'b00, 0, 0, 1, 0, "fwd_ex");
    step(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, "fwd_bubble");
    step(1, 11, 1, 0, 3, 0, 2'b01, 2'b00, 0, 0, 3, 0, "fwd_wb");
    step(1, 12, 1, 0, 3, 0, 2'b01, 2'b00, 0, 0, 0, 0, "fwd_retired");
  endtask

  task automatic test_load_use();
    idle(3);
    step(1, 5, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, "lu_load");
    step(1, 6, 1, 0, 5, 0, 2'b01, 2'b00, 0, 1, 0, 0, "lu_stall");
    step(1, 6, 1, 0, 5, 0, 2'b01, 2'b00, 0, 0, 2, 0, "lu_fwd");
  endtask

  task automatic test_store_late();
    idle(3);
    step(1, 5, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, "st_load");
    step(1, 0, 0, 0, 0, 5, 2'b10, 2'b10, 0, 0, 0, 2, "st_late");
  endtask

  task automatic test_youngest();
    idle(3);
    step(1, 7, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, "yg_w7a");
    step(1, 7, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, "yg_w7b");
    step(1, 0, 1, 0, 7, 0, 2'b01, 2'b00, 0, 0, 1, 0, "yg_youngest");
    step(1, 8, 1, 0, 0, 7, 2'b11, 2'b00, 0, 0, 0, 2, "yg_r0_and_older");
  endtask

  task automatic test_retire_boundary();
    idle(3);
    step(1, 9, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, "rb_add");
    idle(2);
    step(1, 0, 0, 0, 9, 9, 2'b11, 2'b10, 0, 0, 3, 0, "rb_late_past_end");
  endtask

  task automatic test_flush();
    idle(3);
    step(1, 4, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, "fl_load");
    step(1, 8, 1, 0, 4, 0, 2'b01, 2'b00, 1, 0, 0, 0, "fl_issue");
    step(1, 9, 1, 0, 4, 0, 2'b01, 2'b00, 0, 0, 0, 0, "fl_after");
    step(1, 10, 1, 0, 4, 0, 2'b01, 2'b00, 0, 0, 0, 0, "fl_after2");
  endtask

  task automatic test_reset_mid_stall();
    idle(3);
    step(1, 5, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, "rs_load");
    issue_valid = 1; issue_rd = 6; issue_we = 1; issue_is_load = 0;
    src_addr = {5'd0, 5'd5}; src_used = 2'b01; src_late = 2'b00; flush = 0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL rs_pre_stall: got %b want 1", stall);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || stall_cycles !== 16'h0 || satCnt !== 4'h0) begin
      failures++; $display("FAIL rs_async: got stall=%b cnt=%0d sat=%0d want 0/0/0", stall, stall_cycles, satCnt);
    end
    modelCnt = 0;
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || fwd_sel !== 4'h0) begin
      failures++; $display("FAIL rs_released: got stall=%b fwd=%h want 0/0", stall, fwd_sel);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    idle(3);
    step(1, 5, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, "bb_first");
    for (int i = 0; i < 17; i++) begin
      step(1, 5, 1, 1, 5, 0, 2'b01, 2'b00, 0, 1, 0, 0, "bb_stall");
      step(1, 5, 1, 1, 5, 0, 2'b01, 2'b00, 0, 0, 2, 0, "bb_issue");
    end
    idle(1);
    checks++;
    if (satCnt !== 4'hF) begin
      failures++; $display("FAIL bb_saturated: got %h want f", satCnt);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_store_late();
    test_youngest();
    test_retire_boundary();
    test_flush();
    test_reset_mid_stall();
    test_back_to_back();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
